// File: rtl/rv32_dmem_responder.sv
// rtl/rv32_dmem_responder.sv - word-organised data-memory responder with wait states and ERROR response
//
// Purpose: answers the core's data-memory handshake from an internal SRAM that
// sits behind a single address window. Each accepted in-window transfer gets
// WAIT_STATES ready-low cycles followed by one completing cycle. Out-of-window
// transfers get a two-cycle ERROR response and never touch memory.
//
// Ports:
//   mp_clk_in      clock, rising edge
//   mp_rst_in      synchronous active-low reset
//   ms_req_in      transfer request (address phase when sampled with ready=1)
//   ms_addr_in     byte address
//   ms_wr_in       1 = write, 0 = read
//   ms_wr_mask_in  byte-lane strobes for writes
//   ms_wdata_in    write data, captured with the address
//   mp_dmdata_out  read data, non-zero only in a read completion cycle
//   ahb_ready_out  1 = data phase completes or bus idle
//   ahb_resp_out   0 = OKAY, 1 = ERROR
//
// Optional feature macro: RV32_DMEM_ALIGN_CHK_EN (misaligned in-window
// transfers are answered with ERROR instead of completing).
module rv32_dmem_responder #(
  parameter int          ADDR_WIDTH  = 10,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_STATES = 0
) (
  input  logic        mp_clk_in,
  input  logic        mp_rst_in,
  input  logic        ms_req_in,
  input  logic [31:0] ms_addr_in,
  input  logic        ms_wr_in,
  input  logic [3:0]  ms_wr_mask_in,
  input  logic [31:0] ms_wdata_in,
  output logic [31:0] mp_dmdata_out,
  output logic        ahb_ready_out,
  output logic        ahb_resp_out
);

  typedef enum logic [1:0] {IDLE, ACCESS, ERR1, ERR2} state_t;

  localparam logic [3:0] WS = WAIT_STATES[3:0];

  state_t                state, state_nxt;
  logic [3:0]            cnt, cnt_nxt;
  logic [ADDR_WIDTH-1:0] cap_idx;
  logic                  cap_wr;
  logic [3:0]            cap_mask;
  logic [31:0]           cap_wdata;

  logic [31:0]           mem [2**ADDR_WIDTH];

  logic [31:0]           off;
  logic                  in_range;
  logic                  misaligned;
  logic                  done;
  logic                  accept;

  // Offset compare done 34 bits wide so a full 4 GiB window still works and an
  // address below the base wraps to a huge offset, i.e. out of range.
  assign off      = ms_addr_in - BASE_ADDR;
  assign in_range = ({2'b00, off} < (34'd1 << (ADDR_WIDTH + 2)));

`ifdef RV32_DMEM_ALIGN_CHK_EN
  always_comb begin
    misaligned = 1'b0;
    if (!ms_wr_in) begin
      misaligned = (ms_addr_in[1:0] != 2'b00);
    end else if (ms_wr_mask_in == 4'b1111) begin
      misaligned = (ms_addr_in[1:0] != 2'b00);
    end else if (ms_wr_mask_in == 4'b0011 || ms_wr_mask_in == 4'b1100) begin
      misaligned = ms_addr_in[0];
    end
  end
`else
  assign misaligned = 1'b0;
`endif

  // The completing ACCESS cycle can take the next address phase, which makes
  // back-to-back transfers run without a bubble.
  assign done   = (state == ACCESS) && (cnt == 4'd0);
  assign accept = ms_req_in && ((state == IDLE) || done);

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    ahb_ready_out = 1'b1;
    ahb_resp_out  = 1'b0;
    mp_dmdata_out = 32'h0;
    case (state)
      IDLE: begin
      end
      ACCESS: begin
        if (cnt != 4'd0) begin
          ahb_ready_out = 1'b0;
          cnt_nxt       = cnt - 4'd1;
        end else if (!cap_wr) begin
          mp_dmdata_out = mem[cap_idx];
        end
      end
      ERR1: begin
        ahb_ready_out = 1'b0;
        ahb_resp_out  = 1'b1;
        state_nxt     = ERR2;
      end
      ERR2: begin
        ahb_resp_out  = 1'b1;
        state_nxt     = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if ((state == IDLE) || done) begin
      if (accept) begin
        if (in_range && !misaligned) begin
          state_nxt = ACCESS;
          cnt_nxt   = WS;
        end else begin
          state_nxt = ERR1;
          cnt_nxt   = 4'd0;
        end
      end else begin
        state_nxt = IDLE;
      end
    end
  end

  always_ff @(posedge mp_clk_in) begin
    if (!mp_rst_in) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      cap_idx   <= '0;
      cap_wr    <= 1'b0;
      cap_mask  <= 4'b0000;
      cap_wdata <= 32'h0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        cap_idx   <= off[ADDR_WIDTH+1:2];
        cap_wr    <= ms_wr_in;
        cap_mask  <= ms_wr_mask_in;
        cap_wdata <= ms_wdata_in;
      end
    end
  end

  // Memory has no reset; a reset at the committing edge discards the write.
  always_ff @(posedge mp_clk_in) begin
    if (mp_rst_in && done && cap_wr) begin
      for (int i = 0; i < 4; i++) begin
        if (cap_mask[i]) begin
          mem[cap_idx][8*i +: 8] <= cap_wdata[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_rv32_dmem_responder.sv
// tb/tb_rv32_dmem_responder.sv - scoreboard bench for rv32_dmem_responder (0 and 3 wait states)
module tb_rv32_dmem_responder;

  typedef struct {
    logic [31:0] data;
    logic        resp;
    int          waits;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req = 1'b0;
  logic        sel = 1'b0;
  logic [31:0] addr = 32'h0;
  logic        wr = 1'b0;
  logic [3:0]  mask = 4'h0;
  logic [31:0] wdata = 32'h0;

  logic        req0, req3;
  logic [31:0] rdata0, rdata3, rdata_s;
  logic        rdy0, rdy3, rdy_s;
  logic        resp0, resp3, resp_s;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  assign req0    = req & ~sel;
  assign req3    = req & sel;
  assign rdata_s = sel ? rdata3 : rdata0;
  assign rdy_s   = sel ? rdy3 : rdy0;
  assign resp_s  = sel ? resp3 : resp0;

  rv32_dmem_responder #(.ADDR_WIDTH(10), .BASE_ADDR(32'h0), .WAIT_STATES(0)) dut0 (
    .mp_clk_in(clk), .mp_rst_in(rst), .ms_req_in(req0), .ms_addr_in(addr),
    .ms_wr_in(wr), .ms_wr_mask_in(mask), .ms_wdata_in(wdata),
    .mp_dmdata_out(rdata0), .ahb_ready_out(rdy0), .ahb_resp_out(resp0)
  );

  rv32_dmem_responder #(.ADDR_WIDTH(10), .BASE_ADDR(32'h0), .WAIT_STATES(3)) dut3 (
    .mp_clk_in(clk), .mp_rst_in(rst), .ms_req_in(req3), .ms_addr_in(addr),
    .ms_wr_in(wr), .ms_wr_mask_in(mask), .ms_wdata_in(wdata),
    .mp_dmdata_out(rdata3), .ahb_ready_out(rdy3), .ahb_resp_out(resp3)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    req = 1'b0;
    repeat (n) tick();
  endtask

  // Drives a request until its address phase is taken, then returns in the
  // first cycle of the data phase with the request still asserted.
  task automatic xfer(input logic [31:0] a, input logic w, input logic [3:0] m,
                      input logic [31:0] d, input logic [31:0] exp_data,
                      input logic exp_resp, input int exp_waits, input bit push);
    exp_t e;
    int   guard;
    e.data  = exp_data;
    e.resp  = exp_resp;
    e.waits = exp_waits;
    if (push) exp_q.push_back(e);
    addr  = a;
    wr    = w;
    mask  = m;
    wdata = d;
    req   = 1'b1;
    guard = 0;
    while (!rdy_s && guard < 50) begin
      tick();
      guard++;
    end
    if (guard >= 50) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: ready stuck low addr %h", a);
    end
    tick();
  endtask

  // Monitor: tracks accepted address phases and compares each completion
  // against the oldest expected response.
  bit   active = 1'b0;
  bit   zbad   = 1'b0;
  int   wcnt   = 0;
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      active = 1'b0;
      exp_q.delete();
    end else begin
      if (active) begin
        if (!rdy_s) begin
          wcnt++;
          if (rdata_s != 32'h0) zbad = 1'b1;
        end else begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_completion at %0t", $time);
          end else begin
            e = exp_q.pop_front();
            chk("resp", {31'h0, resp_s}, {31'h0, e.resp});
            chk("ready_low_cycles", wcnt, e.waits);
            chk("rdata", rdata_s, e.data);
            chk("rdata_zero_while_waiting", {31'h0, zbad}, 32'h0);
          end
          active = 1'b0;
        end
      end
      if (req && rdy_s) begin
        active = 1'b1;
        wcnt   = 0;
        zbad   = 1'b0;
      end
    end
  end

  initial begin
    int guard;
    // 1: reset held for two edges with a request pending
    sel = 1'b1;
    req = 1'b1; addr = 32'h30; wr = 1'b1; mask = 4'hF; wdata = 32'hFFFF_FFFF;
    tick();
    tick();
    rst = 1'b1;
    req = 1'b0;
    chk("rst_ready_ws3", {31'h0, rdy3}, 32'h1);
    chk("rst_resp_ws3", {31'h0, resp3}, 32'h0);
    chk("rst_rdata_ws3", rdata3, 32'h0);
    chk("rst_ready_ws0", {31'h0, rdy0}, 32'h1);
    chk("rst_resp_ws0", {31'h0, resp0}, 32'h0);
    chk("rst_rdata_ws0", rdata0, 32'h0);

    // 2,3: zero wait states, back-to-back and byte-lane writes
    sel = 1'b0;
    idle(1);
    xfer(32'h000, 1'b1, 4'hF, 32'h1122_3344, 32'h0, 1'b0, 0, 1'b1);
    xfer(32'h010, 1'b1, 4'hF, 32'hDEAD_BEEF, 32'h0, 1'b0, 0, 1'b1);
    xfer(32'h010, 1'b0, 4'hF, 32'h0, 32'hDEAD_BEEF, 1'b0, 0, 1'b1);
    xfer(32'h010, 1'b1, 4'b0100, 32'h00AA_0000, 32'h0, 1'b0, 0, 1'b1);
    xfer(32'h010, 1'b0, 4'h0, 32'h0, 32'hDEAA_BEEF, 1'b0, 0, 1'b1);
    xfer(32'h014, 1'b1, 4'hF, 32'hA5A5_A5A5, 32'h0, 1'b0, 0, 1'b1);
    xfer(32'h014, 1'b1, 4'h0, 32'hFFFF_FFFF, 32'h0, 1'b0, 0, 1'b1);
    xfer(32'h014, 1'b0, 4'h0, 32'h0, 32'hA5A5_A5A5, 1'b0, 0, 1'b1);
    xfer(32'hFFC, 1'b1, 4'hF, 32'h0BAD_C0DE, 32'h0, 1'b0, 0, 1'b1);
    xfer(32'hFFC, 1'b0, 4'h0, 32'h0, 32'h0BAD_C0DE, 1'b0, 0, 1'b1);
    idle(1);

    // 5: out-of-range write, request during ERR1 ignored
    xfer(32'h1000, 1'b1, 4'hF, 32'h1234_5678, 32'h0, 1'b1, 1, 1'b1);
    chk("err1_ready", {31'h0, rdy0}, 32'h0);
    chk("err1_resp", {31'h0, resp0}, 32'h1);
    addr = 32'h000; wr = 1'b1; mask = 4'hF; wdata = 32'hFFFF_FFFF; req = 1'b1;
    tick();
    req = 1'b0;
    chk("err2_ready", {31'h0, rdy0}, 32'h1);
    chk("err2_resp", {31'h0, resp0}, 32'h1);
    tick();
    chk("post_err_ready", {31'h0, rdy0}, 32'h1);
    chk("post_err_resp", {31'h0, resp0}, 32'h0);
    xfer(32'h000, 1'b0, 4'h0, 32'h0, 32'h1122_3344, 1'b0, 0, 1'b1);
    xfer(32'hFFFF_FFFC, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1, 1'b1);
    idle(3);
`ifdef RV32_DMEM_ALIGN_CHK_EN
    xfer(32'h012, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1, 1'b1);
    idle(3);
`else
    xfer(32'h012, 1'b0, 4'h0, 32'h0, 32'hDEAA_BEEF, 1'b0, 0, 1'b1);
    idle(2);
`endif

    // 4: three wait states
    sel = 1'b1;
    idle(1);
    xfer(32'h010, 1'b1, 4'hF, 32'hDEAA_BEEF, 32'h0, 1'b0, 3, 1'b1);
    xfer(32'h010, 1'b0, 4'h0, 32'h0, 32'hDEAA_BEEF, 1'b0, 3, 1'b1);
    xfer(32'h020, 1'b1, 4'hF, 32'h55AA_55AA, 32'h0, 1'b0, 3, 1'b1);

    // 6: reset in the second wait cycle discards the write
    xfer(32'h020, 1'b1, 4'hF, 32'hCAFE_F00D, 32'h0, 1'b0, 3, 1'b0);
    idle(1);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("abort_ready", {31'h0, rdy3}, 32'h1);
    chk("abort_resp", {31'h0, resp3}, 32'h0);
    xfer(32'h020, 1'b0, 4'h0, 32'h0, 32'h55AA_55AA, 1'b0, 3, 1'b1);
    idle(1);

    guard = 0;
    while (exp_q.size() != 0 && guard < 100) begin
      tick();
      guard++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d responses outstanding", exp_q.size());
    end
    idle(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rv32_dmem_responder.md
Name: rv32_dmem_responder

Overview:
- Bus-responder end of the core's data-memory handshake. The core drives request, address, write enable, byte mask and write data; this block answers with mp_dmdata, ahb_ready and ahb_resp.
- Holds a word-organised SRAM behind a single address window.
- Inserts a programmable number of wait states.
- Returns a two-cycle ERROR response for illegal transfers.
- Used as the core's data-memory model and as the baseline slave for later bus fabric.

Parameters:
ADDR_WIDTH, 10, word-address bits; depth = 2**ADDR_WIDTH words.
BASE_ADDR, 32'h0000_0000, byte base of the window; must be aligned to 4*depth.
WAIT_STATES, 0, ready-low cycles inserted per OKAY transfer; legal range 0..15.

Ports:
mp_clk_in  input  1  clock; everything is on the rising edge.
mp_rst_in  input  1  reset, synchronous, active-low.
ms_req_in  input  1  transfer request; it is an address phase when sampled with ahb_ready_out=1.
ms_addr_in  input  32  byte address.
ms_wr_in  input  1  1 = write, 0 = read.
ms_wr_mask_in  input  4  byte strobes; bit n selects byte lane n; ignored for reads.
ms_wdata_in  input  32  write data; captured together with the address.
mp_dmdata_out  output  32  read data; valid only in a read completion cycle.
ahb_ready_out  output  1  1 = current data phase completes or bus idle.
ahb_resp_out  output  1  0 = OKAY, 1 = ERROR.

Behaviour:
- Reset is synchronous, active-low (mp_rst_in=0 at an edge). Next cycle: state IDLE, wait counter 0, ahb_ready_out=1, ahb_resp_out=0, mp_dmdata_out=0, capture registers cleared.
- Memory contents are not reset.
- Reset mid-transfer aborts the transfer. A pending write is discarded.
- FSM states: IDLE, ACCESS, ERR1, ERR2.
- Accept: a request is accepted at an edge when ms_req_in=1 and either:
  - the state is IDLE, or
  - the state is ACCESS with counter=0 (completing cycle); this makes back-to-back transfers zero-bubble.
- On accept, the block latches addr, wr, mask and wdata, then decodes:
  - off = addr - BASE_ADDR.
  - In range when off < 4*2**ADDR_WIDTH (unsigned compare; wrap-around below the base is out of range).
  - In range: go to ACCESS, counter loaded with WAIT_STATES.
  - Out of range: go to ERR1.
- No accept in IDLE or a completing ACCESS: go to / stay in IDLE.
- ACCESS outputs:
  - While counter != 0: ahb_ready_out=0, counter decrements each cycle.
  - While counter = 0: ahb_ready_out=1, ahb_resp_out=0.
  - Read: mp_dmdata_out = mem[off[ADDR_WIDTH+1:2]], the full word.
  - Write: byte lanes with a mask bit of 1 are written at the edge that ends this cycle.
- Outside a read completion cycle, mp_dmdata_out=0.
- Latency: the data phase is exactly WAIT_STATES+1 cycles after the address-phase edge.
- A read at the same address immediately after a write returns the new data, because the write commits before the read's data phase.
- Error handling:
  - ERR1: ahb_ready_out=0, ahb_resp_out=1, then go to ERR2.
  - ERR2: ahb_ready_out=1, ahb_resp_out=1, then go to IDLE.
  - Requests during ERR1/ERR2 are ignored and not accepted.
  - Memory is never modified by an errored transfer.
- A write with mask 4'b0000 completes OKAY and changes nothing.
- When RV32_DMEM_ALIGN_CHK_EN is not defined, addr[1:0] is ignored.

Optional Feature:
- Macro: RV32_DMEM_ALIGN_CHK_EN.
- Defined: an in-range transfer is routed to ERR1 instead of ACCESS when the address is misaligned for its size:
  - reads: addr[1:0] != 0;
  - writes: mask is 4'b1111 with addr[1:0] != 0, or mask is 4'b0011/4'b1100 with addr[0] = 1.
- Not defined: no alignment check; those transfers complete OKAY on the word at off[ADDR_WIDTH+1:2].

Test Plan:
1. Hold mp_rst_in=0 for 2 cycles -> ahb_ready_out=1, ahb_resp_out=0, mp_dmdata_out=0; no accept while in reset.
2. WAIT_STATES=0: write 32'hDEADBEEF to 0x10 with mask 4'b1111, then a back-to-back read of 0x10 -> both complete with no ready-low cycle; read completion cycle shows mp_dmdata_out=32'hDEADBEEF, resp=0.
3. Write 32'h00AA0000 to 0x10 with mask 4'b0100, then read 0x10 -> 32'hDEAABEEF.
4. WAIT_STATES=3: read 0x10 -> ahb_ready_out=0 for exactly 3 cycles, then 1 with 32'hDEAABEEF; mp_dmdata_out=0 during the wait cycles.
5. Write 32'h12345678 to 0x1000 (out of range, ADDR_WIDTH=10) -> ready=0/resp=1, then ready=1/resp=1, then IDLE (ready=1/resp=0); a request during ERR1 is ignored; a read of 0x000 is unchanged.
6. WAIT_STATES=3: write 32'hCAFEF00D to 0x20; assert reset in the 2nd wait cycle -> ready=1/resp=0 after the reset edge; a later read of 0x20 returns its prior value.
   - With RV32_DMEM_ALIGN_CHK_EN defined: read of 0x22 -> two-cycle ERROR.
